switch_in: RTL
==============

Name: switch_in

Overview:
- Read-only I/O-port peripheral that returns the state of 24 board switches to the CPU over the same CS_N / address-bit port bus used by the LED output port.
- Raw switch lines are synchronised, debounced on a divided sample tick and held in a debounced register.
- Two word addresses expose the register: addr 0 = sw[15:0], addr 1 = sw[23:16] plus a change flag.
- A level interrupt flags any debounced change until software acknowledges it.

Parameters:
- SAMPLE_DIV, 50000, clock cycles between debounce samples (1 ms at 50 MHz); legal range >= 2.
- STABLE_N, 4, consecutive identical samples required before a debounced bit updates; legal range 2..8.

Ports:
- wb_clk_i  input  1  system clock; all state on rising edge.
- wb_rst_n_i  input  1  asynchronous active-low reset.
- wb_adr_i  input  1  word select: 0 = low half, 1 = high half / status.
- IOR_N  input  1  active-low read strobe.
- CS_N  input  1  active-low chip select.
- sw_in  input  24  raw asynchronous switch lines.
- wb_dat_o  output  16  registered read data.
- sw_irq  output  1  level interrupt: debounced value changed since last acknowledge.

Behaviour:
- Reset (wb_rst_n_i low, asynchronous):
  - Clear the synchronisers, sample history, prescaler, debounced register sw_q, hi-byte snapshot, change flag, wb_dat_o and sw_irq to 0.
  - On reset release, switches that are already on become visible only after normal debounce. This also produces a change event.
- Synchroniser: two-flop chain per bit (sw_s). No other logic sees sw_in directly.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1, then wraps to 0.
  - Asserts a one-cycle sample tick on the wrap cycle. First tick is SAMPLE_DIV cycles after reset release.
- Sample history, per bit:
  - STABLE_N-deep shift register, shifted with sw_s only on a tick.
  - On the cycle after a tick, if all STABLE_N entries of a bit are equal and differ from sw_q[bit], sw_q[bit] takes that value. Otherwise sw_q[bit] holds.
  - Bits update independently; several bits may change in the same cycle.
- Worst-case latency, stable input change to sw_q: 2 sync cycles + STABLE_N*SAMPLE_DIV + 1 cycles.
- Read strobe and edge:
  - rd = !CS_N & !IOR_N.
  - rd_edge = rd & !rd_d, where rd_d is rd registered.
- Read data:
  - wb_dat_o updates every cycle rd is high and holds otherwise; one-cycle latency.
  - adr 0: wb_dat_o <= sw_q[15:0]. On rd_edge at adr 0, snapshot sw_q[23:16] into hi_snap.
  - adr 1: wb_dat_o <= {7'b0, chg_flag, hi_snap}.
  - Reading adr 0 then adr 1 therefore returns a coherent 24-bit value even if sw_q changes between the reads.
  - hi_snap resets to 0. Reading adr 1 without a prior adr 0 read returns the last snapshot.
- Change flag:
  - chg_flag sets on any cycle where sw_q changes.
  - Clears on rd_edge at adr 1. The data returned for that read shows chg_flag = 1, the pre-clear value.
  - If a set and a clear occur in the same cycle, set wins and the flag stays 1.
  - sw_irq = chg_flag, registered with no extra delay.
- Writes: IOW_N is not a port; the block ignores all write cycles.
- A held rd strobe (multi-cycle read) produces exactly one snapshot or clear, on its first cycle.
- Reset asserted mid-debounce: all history is discarded. After release the debounce restarts from zero history.
- Glitches shorter than STABLE_N ticks never reach sw_q.

Test Plan (bench uses SAMPLE_DIV=4, STABLE_N=3):
- Reset and basic read:
  - Hold wb_rst_n_i low with sw_in=24'hA5F00F, then release.
  - sw_q = 24'hA5F00F no later than 2+12+1 = 15 cycles after release. sw_irq = 1.
  - Read adr 0 -> wb_dat_o = 16'hF00F one cycle later.
  - Read adr 1 -> wb_dat_o = 16'h01A5, and sw_irq drops the cycle after the rd edge.
- Bounce rejection:
  - After settling at 0, toggle sw_in[3] every 5 cycles for 40 cycles, then return to 0.
  - sw_q stays 0 and sw_irq stays 0 throughout.
- Coherent snapshot:
  - sw_q = 24'h12_3456; read adr 0 -> 16'h3456.
  - Change sw_in to 24'h780000 and wait for the debounce to complete.
  - Read adr 1 -> 16'h0112 (old hi byte 12, flag 1).
  - Reread adr 0 then adr 1 -> 16'h0000, then 16'h0078 (flag already cleared, no new change).
- Set/clear collision:
  - Time a debounced change to land in the same cycle as the adr 1 rd_edge.
  - sw_irq remains 1 afterwards.
  - A second adr 1 read clears it.
- Held strobe:
  - Hold rd on adr 1 for 6 cycles while a new change lands on cycle 4.
  - chg_flag is cleared only on cycle 1; it is set again by the cycle-4 change and remains 1 after the strobe ends.
- Reset mid-operation:
  - Assert wb_rst_n_i for 1 cycle during an in-progress debounce of bit 20.
  - wb_dat_o, sw_irq and sw_q are 0 immediately, asynchronously.
  - Bit 20 appears again only after a full 15-cycle debounce from release.

Source files
------------

// File: rtl/switch_in.sv
// Read-only switch input port: 24 raw switch lines are synchronised, debounced
// on a divided sample tick and read back as two 16-bit words with a change interrupt.
module switch_in #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_N   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_adr_i,
  input  logic        IOR_N,
  input  logic        CS_N,
  input  logic [23:0] sw_in,
  output logic [15:0] wb_dat_o,
  output logic        sw_irq
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [23:0]   sw_meta;
  logic [23:0]   sw_s;
  logic [CW-1:0] pre_cnt;
  logic          tick;
  logic          tick_d;
  logic [23:0]   hist [STABLE_N];
  logic [23:0]   all_one;
  logic [23:0]   all_zero;
  logic [23:0]   sw_q;
  logic [23:0]   sw_q_next;
  logic [7:0]    hi_snap;
  logic          chg_flag;
  logic          chg_set;
  logic          chg_clr;
  logic          rd;
  logic          rd_d;
  logic          rd_edge;
  logic          snap_en;

  assign tick    = (pre_cnt == CW'(SAMPLE_DIV - 1));
  assign rd      = ~CS_N & ~IOR_N;
  assign rd_edge = rd & ~rd_d;
  assign snap_en = rd_edge & ~wb_adr_i;
  assign chg_clr = rd_edge & wb_adr_i;
  assign chg_set = (sw_q_next != sw_q);
  assign sw_irq  = chg_flag;

  // A bit only moves when its whole history agrees and differs from the held value.
  always_comb begin
    all_one  = {24{1'b1}};
    all_zero = {24{1'b1}};
    for (int i = 0; i < STABLE_N; i++) begin
      all_one  = all_one & hist[i];
      all_zero = all_zero & ~hist[i];
    end
    if (tick_d) begin
      sw_q_next = (sw_q | all_one) & ~all_zero;
    end else begin
      sw_q_next = sw_q;
    end
  end

  // Synchroniser, prescaler and per-bit sample history.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sw_meta <= 24'h0;
      sw_s    <= 24'h0;
      pre_cnt <= {CW{1'b0}};
      tick_d  <= 1'b0;
      for (int i = 0; i < STABLE_N; i++) begin
        hist[i] <= 24'h0;
      end
    end else begin
      sw_meta <= sw_in;
      sw_s    <= sw_meta;
      tick_d  <= tick;
      if (tick) begin
        pre_cnt <= {CW{1'b0}};
        hist[0] <= sw_s;
        for (int i = 1; i < STABLE_N; i++) begin
          hist[i] <= hist[i-1];
        end
      end else begin
        pre_cnt <= pre_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Debounced value, change flag (set beats clear), hi-byte snapshot and read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sw_q     <= 24'h0;
      chg_flag <= 1'b0;
      hi_snap  <= 8'h0;
      rd_d     <= 1'b0;
      wb_dat_o <= 16'h0;
    end else begin
      sw_q <= sw_q_next;
      rd_d <= rd;
      if (chg_set) begin
        chg_flag <= 1'b1;
      end else if (chg_clr) begin
        chg_flag <= 1'b0;
      end
      if (snap_en) begin
        hi_snap <= sw_q[23:16];
      end
      if (rd) begin
        if (wb_adr_i) begin
          wb_dat_o <= {7'b0, chg_flag, hi_snap};
        end else begin
          wb_dat_o <= sw_q[15:0];
        end
      end
    end
  end

endmodule
